// File: rtl/delay_line_ctrl_if.sv
// Sample stream and FIFO-side signals of the delay line controller.
// master is the controller's view, slave is the view of the source/sink/FIFO side.
interface delay_line_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_ready;
  logic [WIDTH-1:0] sample_out;
  logic             sample_out_valid;
  logic [WIDTH-1:0] fifo_data_in;
  logic             fifo_wr_en;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_empty;
  logic             fifo_full;

  modport master (
    input  sample_in, sample_valid, fifo_data_out, fifo_empty, fifo_full,
    output sample_ready, sample_out, sample_out_valid,
           fifo_data_in, fifo_wr_en, fifo_rd_en
  );

  modport slave (
    output sample_in, sample_valid, fifo_data_out, fifo_empty, fifo_full,
    input  sample_ready, sample_out, sample_out_valid,
           fifo_data_in, fifo_wr_en, fifo_rd_en
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// Programmable sample delay line built around one external synchronous FIFO.
// Define DELAY_LINE_CTRL_ZERO_FILL_EN to emit a zero sample for every accept while priming.
module delay_line_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 10,
  parameter int DELAY_WIDTH = $clog2(DEPTH),
  parameter int CTR_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DELAY_WIDTH-1:0] delay,
  delay_line_ctrl_if.master      bus
);

  typedef enum logic [1:0] {FLUSH, IDLE, FILL, RUN} state_t;

  // A write is dropped while the FIFO is full even with a read in the same cycle,
  // so the steady occupancy must stay one below DEPTH.
  localparam logic [DELAY_WIDTH-1:0] DELAY_MAX = DELAY_WIDTH'(DEPTH - 1);

  function automatic logic [DELAY_WIDTH-1:0] sat_delay(input logic [DELAY_WIDTH-1:0] d);
    return (d > DELAY_MAX) ? DELAY_MAX : d;
  endfunction

  state_t                 state, state_nxt;
  logic [DELAY_WIDTH-1:0] delay_eff, delay_q;
  logic [CTR_WIDTH-1:0]   fill_count;
  logic                   accept, reconfig, load_fill;
  logic                   wr_en, rd_en;
  logic                   emit_byp, emit_zero, emit_fifo;
  logic                   vld_p1, sel_fifo_p1;
  logic [WIDTH-1:0]       byp_p1;

  assign delay_eff = sat_delay(delay);
  assign reconfig  = !enable || (delay_eff != delay_q);
  assign accept    = bus.sample_valid && bus.sample_ready;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    emit_byp  = 1'b0;
    emit_zero = 1'b0;
    emit_fifo = 1'b0;
    load_fill = 1'b0;
    case (state)
      FLUSH: begin
        // Reset gates the read strobe so all outputs are quiet while reset is held.
        rd_en = !bus.fifo_empty && !reset;
        if (bus.fifo_empty) begin
          if (enable) begin
            state_nxt = FILL;
            load_fill = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      IDLE: begin
        if (enable) begin
          state_nxt = FILL;
          load_fill = 1'b1;
        end
      end
      FILL: begin
        if (delay_q == '0) begin
          // Nothing to prime: a sample arriving now is already on the bypass path.
          emit_byp  = accept;
          state_nxt = RUN;
        end else begin
          wr_en = accept;
`ifdef DELAY_LINE_CTRL_ZERO_FILL_EN
          emit_zero = accept;
`endif
          if (accept && ((fill_count + CTR_WIDTH'(1)) == CTR_WIDTH'(delay_q)))
            state_nxt = RUN;
        end
        if (reconfig) state_nxt = FLUSH;
      end
      RUN: begin
        if (delay_q == '0) begin
          emit_byp = accept;
        end else begin
          wr_en     = accept;
          rd_en     = accept;
          emit_fifo = accept;
        end
        if (reconfig) state_nxt = FLUSH;
      end
      default: state_nxt = FLUSH;
    endcase
  end

  // p0 -> p1: control state and output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FLUSH;
      delay_q     <= '0;
      fill_count  <= '0;
      vld_p1      <= 1'b0;
      sel_fifo_p1 <= 1'b0;
      byp_p1      <= '0;
    end else begin
      state <= state_nxt;
      if (load_fill) begin
        delay_q    <= delay_eff;
        fill_count <= '0;
      end else if (state == FILL && wr_en) begin
        fill_count <= fill_count + CTR_WIDTH'(1);
      end
      vld_p1      <= emit_byp || emit_zero || emit_fifo;
      sel_fifo_p1 <= emit_fifo;
      if (emit_byp)       byp_p1 <= bus.sample_in;
      else if (emit_zero) byp_p1 <= '0;
    end
  end

  assign bus.sample_ready     = (state != FLUSH);
  assign bus.fifo_data_in     = bus.sample_in;
  assign bus.fifo_wr_en       = wr_en;
  assign bus.fifo_rd_en       = rd_en;
  assign bus.sample_out_valid = vld_p1;
  assign bus.sample_out       = sel_fifo_p1 ? bus.fifo_data_out : byp_p1;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: FIFO model, directed scenarios and a randomized run against a queue model.
module tb_delay_line_ctrl;
  localparam int W = 8;
  localparam int D = 10;
`ifdef DELAY_LINE_CTRL_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] delay = 4'd0;
  always #5 clk = ~clk;

  delay_line_ctrl_if #(.WIDTH(W)) bus ();

  delay_line_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .delay  (delay),
    .bus    (bus.master)
  );

  // Synchronous FIFO: registered read data, writes dropped when full, reads ignored when empty.
  logic [W-1:0] mem [D];
  int           f_wp = 0, f_rp = 0, f_cnt = 0;
  logic [W-1:0] f_dout = '0;
  logic         pre_wr = 1'b0;
  logic [W-1:0] pre_data = '0;
  logic         f_wr, f_rd_ok, f_wr_ok;
  logic [W-1:0] f_din;

  assign f_wr              = bus.fifo_wr_en | pre_wr;
  assign f_din             = pre_wr ? pre_data : bus.fifo_data_in;
  assign f_rd_ok           = bus.fifo_rd_en && (f_cnt != 0);
  assign f_wr_ok           = f_wr && (f_cnt != D);
  assign bus.fifo_data_out = f_dout;
  assign bus.fifo_empty    = (f_cnt == 0);
  assign bus.fifo_full     = (f_cnt == D);

  always @(posedge clk) begin
    if (f_rd_ok) begin
      f_dout <= mem[f_rp];
      f_rp   <= (f_rp + 1) % D;
    end
    if (f_wr_ok) begin
      mem[f_wp] <= f_din;
      f_wp      <= (f_wp + 1) % D;
    end
    f_cnt <= f_cnt + int'(f_wr_ok) - int'(f_rd_ok);
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: per active segment, the accepted samples in order; output k is accept k-d.
  int         q[$];
  int         d_m = 0;
  bit         on = 1'b0;
  bit         prev_en = 1'b0;
  int         prev_delay = 0;
  bit         exp_vld = 1'b0;
  logic [7:0] exp_data = '0;
  int         rd_cnt = 0;
  int         outs[$];

  function automatic int clampd(input int x);
    return (x > D - 1) ? D - 1 : x;
  endfunction

  task automatic eval();
    bit         acc, fill_done, nv;
    logic [7:0] nd;
    chk("out_valid", bus.sample_out_valid, exp_vld);
    if (exp_vld) chk("out_data", bus.sample_out, exp_data);
    if (bus.sample_out_valid) outs.push_back(int'(bus.sample_out));
    chk("illegal_strobe", (bus.fifo_wr_en && bus.fifo_full && !bus.fifo_rd_en) ||
                          (bus.fifo_rd_en && bus.fifo_empty), 0);
    acc = bus.sample_valid && bus.sample_ready;
    nv  = 1'b0;
    nd  = '0;
    if (bus.sample_ready && !on && prev_en) begin
      on  = 1'b1;
      d_m = clampd(prev_delay);
      q.delete();
    end
    if (!bus.sample_ready) begin
      on = 1'b0;
      if (bus.fifo_rd_en) rd_cnt++;
      chk("flush_rd", bus.fifo_rd_en, !bus.fifo_empty);
      chk("flush_wr", bus.fifo_wr_en, 0);
    end else if (!on) begin
      chk("idle_strobes", {bus.fifo_wr_en, bus.fifo_rd_en}, 0);
    end else begin
      fill_done = (q.size() >= d_m);
      chk("wr_en", bus.fifo_wr_en, acc && d_m > 0);
      chk("rd_en", bus.fifo_rd_en, acc && d_m > 0 && fill_done);
      chk("full_in_line", bus.fifo_full, 0);
      if (acc) begin
        q.push_back(int'(bus.sample_in));
        if (q.size() > d_m) begin
          nv = 1'b1;
          nd = 8'(q.pop_front());
        end else if (ZF) begin
          nv = 1'b1;
        end
      end
      if (!enable || clampd(int'(delay)) != d_m) on = 1'b0;
    end
    prev_en    = enable;
    prev_delay = int'(delay);
    exp_vld    = nv;
    exp_data   = nd;
  endtask

  task automatic step(input logic v, input logic [7:0] dat);
    bus.sample_valid = v;
    bus.sample_in    = dat;
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.sample_ready && n < 40) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk(tag, bus.sample_ready, 1);
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_ready"}, bus.sample_ready, 0);
    chk({pfx, "_out_valid"}, bus.sample_out_valid, 0);
    chk({pfx, "_out"}, bus.sample_out, 0);
    chk({pfx, "_wr"}, bus.fifo_wr_en, 0);
    chk({pfx, "_rd"}, bus.fifo_rd_en, 0);
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;

    // Reset held while the FIFO is preloaded with four stale entries.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pre_wr   = 1'b1;
      pre_data = 8'(8'hE0 + k);
    end
    @(negedge clk);
    pre_wr = 1'b0;
    chk("preload_cnt", f_cnt, 4);
    chk_quiet("rst");
    enable = 1'b1;
    delay  = 4'd3;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    rd_cnt = 0;
    wait_ready("ready_after_reset");
    chk("reset_flush_reads", rd_cnt, 4);

    // Steady delay 3: samples 1..10 back to back.
    outs.delete();
    for (int k = 1; k <= 10; k++) step(1'b1, 8'(k));
    step(1'b0, 8'h00);
    chk("steady_count", outs.size(), ZF ? 10 : 7);
    chk("steady_first", outs[0], ZF ? 0 : 1);
    chk("steady_last", outs[outs.size() - 1], 7);

    // Gapped input at delay 2.
    delay  = 4'd2;
    rd_cnt = 0;
    step(1'b0, 8'h00);
    wait_ready("ready_gapped");
    chk("gapped_flush_reads", rd_cnt, 3);
    for (int k = 0; k < 16; k++) step(k[0] == 1'b0, 8'($urandom));

    // Reconfigure 5 -> 2 while running.
    delay = 4'd5;
    step(1'b0, 8'h00);
    wait_ready("ready_d5");
    for (int k = 0; k < 10; k++) step(1'b1, 8'(8'h40 + k));
    delay  = 4'd2;
    rd_cnt = 0;
    step(1'b1, 8'h4A);
    chk("reconf_ready_low", bus.sample_ready, 0);
    wait_ready("ready_reconf");
    chk("reconf_flush_reads", rd_cnt, 5);
    for (int k = 0; k < 6; k++) step(1'b1, 8'(8'h50 + k));

    // Clamp: requested 15 saturates to 9.
    delay = 4'd15;
    step(1'b0, 8'h00);
    wait_ready("ready_clamp");
    for (int k = 0; k < 20; k++) step(1'b1, 8'(8'h60 + k));
    chk("clamp_occupancy", f_cnt, 9);

    // Bypass.
    delay  = 4'd0;
    rd_cnt = 0;
    step(1'b0, 8'h00);
    wait_ready("ready_bypass");
    chk("bypass_flush_reads", rd_cnt, 9);
    outs.delete();
    step(1'b1, 8'hA5);
    step(1'b0, 8'h00);
    chk("bypass_count", outs.size(), 1);
    chk("bypass_data", outs[0], 8'hA5);

    // Disabled: accepts are discarded in IDLE.
    enable = 1'b0;
    step(1'b0, 8'h00);
    wait_ready("ready_idle");
    outs.delete();
    for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h70 + k));
    chk("idle_no_output", outs.size(), 0);
    enable = 1'b1;
    delay  = 4'd4;
    step(1'b0, 8'h00);
    for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h80 + k));

    // Asynchronous reset asserted mid-cycle with four entries in the FIFO.
    bus.sample_valid = 1'b1;
    bus.sample_in    = 8'h77;
    #2;
    reset = 1'b1;
    #1;
    chk_quiet("midrst");
    on      = 1'b0;
    exp_vld = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    reset            = 1'b0;
    bus.sample_valid = 1'b0;
    prev_en          = enable;
    prev_delay       = int'(delay);
    rd_cnt           = 0;
    wait_ready("ready_after_midrst");
    chk("midrst_flush_reads", rd_cnt, 4);

    // Randomized traffic with occasional reconfiguration and disable.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) delay = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      step($urandom_range(0, 9) < 7, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Sequencer that turns one synchronous FIFO instance (read data registered, one-cycle latency, writes ignored when full, reads ignored when empty) into a programmable sample delay line. Sits between the sample source and the FIFO: accepts input samples, drives the FIFO write and read strobes, primes the FIFO to the requested depth and flushes it on reconfiguration. The delayed stream is presented with a valid strobe.

## Interface
- `WIDTH`, 8: sample width; must match the FIFO's `WIDTH`.
- `DEPTH`, 10: FIFO depth; must match the FIFO's `DEPTH`.
- `DELAY_WIDTH`, `$clog2(DEPTH)`: width of the `delay` input.
- `CTR_WIDTH`, `$clog2(DEPTH+1)`: width of the fill counter.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request; low stops the line and empties it.
- `delay`  in  DELAY_WIDTH  requested delay in samples; clamped to DEPTH-1.
- `sample_in`  in  WIDTH  input sample.
- `sample_valid`  in  1  `sample_in` is present this cycle.
- `sample_ready`  out  1  controller accepts `sample_in` this cycle.
- `sample_out`  out  WIDTH  delayed sample; only meaningful when `sample_out_valid` is high.
- `sample_out_valid`  out  1  one-cycle strobe per output sample.
- `fifo_data_in`  out  WIDTH  to FIFO `data_in`; equals `sample_in`.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_rd_en`  out  1  to FIFO `rd_en`.
- `fifo_data_out`  in  WIDTH  from FIFO `data_out`.
- `fifo_empty`, `fifo_full`  in  1 each  from the FIFO.

## Operation
- The controller has four states: FLUSH, IDLE, FILL and RUN.
- **Accept rule:** a sample is accepted when `sample_valid && sample_ready`.
  - `sample_ready` is 0 in FLUSH and 1 otherwise.
- **Delay clamp:** `delay_eff = min(delay, DEPTH-1)`.
  - DEPTH-1 is the limit because the FIFO drops a write while full, even if a read is issued in the same cycle.
- **Delay latch:** `delay_q` captures `delay_eff` on entry to FILL.
- **FLUSH:**
  - Drive `fifo_rd_en = !fifo_empty`; the data read out is discarded.
  - When `fifo_empty` is high, go to FILL if `enable`, otherwise to IDLE.
- **IDLE:**
  - Accepted samples are discarded; there are no FIFO strobes.
  - When `enable` rises, go to FILL.
- **FILL:**
  - `fill_count` is cleared on entry.
  - Each accepted sample drives `fifo_wr_en` and increments `fill_count`.
  - When `delay_q == 0`, go to RUN immediately with no write.
  - When an accepted sample is the `delay_q`-th write, go to RUN on the next cycle.
- **RUN, `delay_q > 0`:** each accepted sample drives `fifo_wr_en` and `fifo_rd_en` in the same cycle, so FIFO occupancy stays at `delay_q`.
- **RUN, `delay_q == 0`:** bypass mode. There are no FIFO strobes, and `sample_in` is registered straight to the output.
- **Leaving FILL/RUN:**
  - In FILL or RUN, `!enable` or `delay_eff != delay_q` sends the controller to FLUSH on the next cycle.
  - A sample accepted in that same cycle is still processed normally.
- **Output mux:** `sample_out` is `fifo_data_out` when the pending output came from a FIFO read. Otherwise it is an internal register holding the bypass sample or zero.

## Timing
- **Reset (async):**
  - State goes to FLUSH; `fill_count`, `delay_q` and the bypass register clear to 0.
  - `sample_out_valid=0`, `fifo_wr_en=0`, `fifo_rd_en=0`, `sample_ready=0`, `sample_out=0`.
  - FLUSH after reset empties a FIFO whose own synchronous reset was not applied.
- **Latency:** `sample_out_valid` pulses exactly 1 cycle after an accepted sample in RUN.
  - The data is the sample accepted `delay_q` accepts earlier.
- Input stalls never cause output gaps or duplicates; the output count always equals the accept count in RUN.
- **Flush duration:** at most DEPTH cycles of `fifo_rd_en`, plus 1 cycle to observe `fifo_empty`.
- **Fault strobes:**
  - `fifo_full` high in RUN is a fault.
  - `fifo_wr_en` must never be asserted while `fifo_full` is high, or `fifo_rd_en` while `fifo_empty` is high, except for the same-cycle write+read in RUN.

## Configuration
- `DELAY_LINE_CTRL_ZERO_FILL_EN` defined:
  - Each sample accepted in FILL produces `sample_out_valid` one cycle later with `sample_out = 0`.
  - The output rate therefore equals the input rate from the first sample.
- Undefined:
  - FILL produces no output.
  - The first `sample_out_valid` follows the first accept in RUN.

## Test plan
- **Reset/flush:** DEPTH=10, FIFO preloaded with 4 entries, assert `reset` mid-cycle.
  - All outputs are 0 immediately.
  - Exactly 4 `fifo_rd_en` cycles, then FILL with `sample_ready=1`.
- **Steady delay:** `delay=3`, input 1,2,3,…,10 one per cycle.
  - `sample_out` = 1..7 on consecutive cycles, starting 1 cycle after the 4th accept.
  - With ZERO_FILL: three zeros precede them.
- **Gapped input:** `delay=2`, `sample_valid` toggling every cycle.
  - Valids track accepts with 1-cycle latency, no duplicates.
  - Output sequence equals input shifted by 2.
- **Boundary clamp:** DEPTH=8, `delay=7`, then hold 20 samples.
  - Occupancy stays at 7, `fifo_full` never asserts, sample N comes out with sample N+7.
- **Bypass:** `delay=0`, input 0xA5.
  - `sample_out=0xA5` valid 1 cycle later; no FIFO strobes.
- **Reconfigure:** change `delay` from 5 to 2 mid-RUN.
  - FLUSH reads 5 entries with `sample_ready=0`.
  - Then FILL of 2; new outputs are delayed by 2.
